mont_mul: RTL and testbench

- Word-serial Montgomery multiplier that computes result = a * b * R^-1 mod n, with R = 2^WIDTH.
- Sits directly downstream of the R-mod-n / R^2-mod-n generator and the modular-inverse unit, and consumes what they produce:
  - n and R^2 mod n convert operands into the Montgomery domain.
  - n_inv = -n^-1 mod 2^LIMB drives the per-iteration reduction.
- It is the core that the modular-exponentiation controller sequences.
- Uses the CIOS algorithm with one LIMB x LIMB multiply-accumulate per cycle.

---
 rtl/mont_pkg.sv | 23 ++
 rtl/mont_limb_mac.sv | 26 ++
 rtl/mont_mul.sv | 234 +++++++++++++++++++++++
 tb/tb_mont_mul.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared constants and types for the word-serial Montgomery multiplier.
package mont_pkg;

  localparam int WIDTH_DEF = 4096;
  localparam int LIMB_DEF  = 64;
  localparam int NLIMB_DEF = WIDTH_DEF / LIMB_DEF;

  // Limb index width: must reach t[NLIMB+1] of the accumulator.
  localparam int IDX_W_DEF = $clog2(NLIMB_DEF + 2);

  // CIOS sequencing; SUB also hosts the one-cycle final select.
  typedef enum logic [2:0] {
    IDLE,
    MULA,
    ACC,
    RED0,
    REDN,
    FIX,
    SUB,
    DONE
  } state_e;

endpackage : mont_pkg

// File: rtl/mont_limb_mac.sv
// Single-limb multiply-accumulate: {hi,lo} = x + y*z + c.
// Kept separate so a DSP-mapped or pipelined multiplier can drop in.
module mont_limb_mac
  import mont_pkg::*;
#(
  parameter int LIMB = LIMB_DEF
) (
  input  logic [LIMB-1:0] x,
  input  logic [LIMB-1:0] y,
  input  logic [LIMB-1:0] z,
  input  logic [LIMB-1:0] c,
  output logic [LIMB-1:0] hi,
  output logic [LIMB-1:0] lo
);

  logic [2*LIMB-1:0] sum;

  // Full-width sum; (2^L-1) + (2^L-1)^2 + (2^L-1) = 2^2L - 1, so it never overflows.
  always_comb begin
    sum = (2*LIMB)'(y) * (2*LIMB)'(z) + (2*LIMB)'(x) + (2*LIMB)'(c);
  end

  assign hi = sum[2*LIMB-1:LIMB];
  assign lo = sum[LIMB-1:0];

endmodule : mont_limb_mac

// File: rtl/mont_mul.sv
// Word-serial CIOS Montgomery multiplier: result = a*b*R^-1 mod n, R = 2^WIDTH.
// One LIMB x LIMB MAC per cycle, shared by the multiply and reduce passes.
module mont_mul
  import mont_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int LIMB  = LIMB_DEF,
  localparam int NLIMB = WIDTH / LIMB
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  input  logic [LIMB-1:0]  n_inv,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  localparam int IDXW = $clog2(NLIMB + 2);
  localparam int LW   = (NLIMB > 1) ? $clog2(NLIMB) : 1;

  typedef logic [LIMB-1:0] limb_t;
  typedef logic [IDXW-1:0] idx_t;

  localparam idx_t  ONE      = idx_t'(1);
  localparam idx_t  LAST_J   = idx_t'(NLIMB - 1);
  localparam idx_t  SEL_J    = idx_t'(NLIMB);
  localparam limb_t LIMB_ONE = limb_t'(1);

  state_e state_q, state_d;

  limb_t a_q [NLIMB];
  limb_t b_q [NLIMB];
  limb_t n_q [NLIMB];
  limb_t n_inv_q;

  limb_t t_q [NLIMB+2];
  limb_t t_d [NLIMB+2];
  limb_t d_q [NLIMB];
  limb_t d_d [NLIMB];

  limb_t c_q, c_d;
  limb_t m_q, m_d;
  logic  borrow_q, borrow_d;
  idx_t  i_q, i_d;
  idx_t  j_q, j_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic          accept;
  logic [LW-1:0] jl, il;
  idx_t          j_m1;
  limb_t         m_now;
  logic [LIMB:0] top_sum;
  logic [LIMB:0] diff;
  logic [WIDTH-1:0] t_flat, d_flat;

  limb_t mac_x, mac_y, mac_z, mac_c, mac_hi, mac_lo;

  assign accept  = go && (state_q == IDLE || state_q == DONE);
  assign jl      = j_q[LW-1:0];
  assign il      = i_q[LW-1:0];
  assign j_m1    = j_q - ONE;
  assign m_now   = t_q[0] * n_inv_q;
  assign top_sum = {1'b0, t_q[NLIMB]} + {1'b0, c_q};
  assign diff    = {1'b0, t_q[j_q]} - {1'b0, n_q[jl]} - {{LIMB{1'b0}}, borrow_q};
  assign result  = result_q;

  mont_limb_mac #(.LIMB(LIMB)) u_mac (
    .x  (mac_x),
    .y  (mac_y),
    .z  (mac_z),
    .c  (mac_c),
    .hi (mac_hi),
    .lo (mac_lo)
  );

  // State register; reset aborts any operation without a done pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state sequencing through the CIOS passes.
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (accept) state_d = MULA;
      MULA:       if (j_q == LAST_J) state_d = ACC;
      ACC:        state_d = RED0;
      RED0:       state_d = REDN;
      REDN:       if (j_q == LAST_J) state_d = FIX;
      FIX:        state_d = (i_q == LAST_J) ? SUB : MULA;
      SUB:        if (j_q == SEL_J) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy = (state_q != IDLE) && (state_q != DONE);
    done = (state_q == DONE);
  end

  // MAC operand mux: MULA uses a[j]*b[i], RED0 uses m*n[0], REDN uses m*n[j].
  always_comb begin
    mac_x = t_q[j_q];
    mac_y = a_q[jl];
    mac_z = b_q[il];
    mac_c = '0;
    unique case (state_q)
      MULA:    mac_c = (j_q == '0) ? '0 : c_q;
      RED0: begin
        mac_y = m_now;
        mac_z = n_q[0];
      end
      REDN: begin
        mac_y = m_q;
        mac_z = n_q[jl];
        mac_c = c_q;
      end
      default: ;
    endcase
  end

  // Flatten accumulator and difference limbs for the final select.
  always_comb begin
    for (int k = 0; k < NLIMB; k++) begin
      t_flat[k*LIMB +: LIMB] = t_q[k];
      d_flat[k*LIMB +: LIMB] = d_q[k];
    end
  end

  // Datapath next-state: accumulate, reduce, fold carries, subtract, select.
  always_comb begin
    t_d      = t_q;
    d_d      = d_q;
    c_d      = c_q;
    m_d      = m_q;
    borrow_d = borrow_q;
    i_d      = i_q;
    j_d      = j_q;
    result_d = result_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          for (int k = 0; k < NLIMB + 2; k++) t_d[k] = '0;
          c_d = '0;
          i_d = '0;
          j_d = '0;
        end
      end
      MULA: begin
        t_d[j_q] = mac_lo;
        c_d      = mac_hi;
        j_d      = (j_q == LAST_J) ? '0 : j_q + ONE;
      end
      ACC: begin
        t_d[NLIMB]   = top_sum[LIMB-1:0];
        t_d[NLIMB+1] = {{(LIMB-1){1'b0}}, top_sum[LIMB]};
      end
      RED0: begin
        // Low limb of t[0] + m*n[0] is zero by choice of m; only the carry survives.
        m_d = m_now;
        c_d = mac_hi;
        j_d = ONE;
      end
      REDN: begin
        t_d[j_m1] = mac_lo;
        c_d       = mac_hi;
        j_d       = (j_q == LAST_J) ? '0 : j_q + ONE;
      end
      FIX: begin
        t_d[NLIMB-1] = top_sum[LIMB-1:0];
        t_d[NLIMB]   = t_q[NLIMB+1] + {{(LIMB-1){1'b0}}, top_sum[LIMB]};
        t_d[NLIMB+1] = '0;
        i_d          = i_q + ONE;
        j_d          = '0;
        borrow_d     = 1'b0;
      end
      SUB: begin
        if (j_q == SEL_J) begin
          // t < 2n here; subtract once when t carries past R or t >= n.
          result_d = (t_q[NLIMB] == LIMB_ONE || !borrow_q) ? d_flat : t_flat;
        end else begin
          d_d[jl]  = diff[LIMB-1:0];
          borrow_d = diff[LIMB];
          j_d      = j_q + ONE;
        end
      end
      default: ;
    endcase
  end

  // Resettable datapath registers: accumulator, carries, counters, result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NLIMB + 2; k++) t_q[k] <= '0;
      c_q      <= '0;
      m_q      <= '0;
      borrow_q <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
      result_q <= '0;
    end else begin
      t_q      <= t_d;
      c_q      <= c_d;
      m_q      <= m_d;
      borrow_q <= borrow_d;
      i_q      <= i_d;
      j_q      <= j_d;
      result_q <= result_d;
    end
  end

  // Operand capture on accept and the subtraction scratch limbs.
  always_ff @(posedge clk) begin
    // NOTE: these wide registers carry no reset; each is written before it is read in every operation.
    if (accept) begin
      for (int k = 0; k < NLIMB; k++) begin
        a_q[k] <= a[k*LIMB +: LIMB];
        b_q[k] <= b[k*LIMB +: LIMB];
        n_q[k] <= n[k*LIMB +: LIMB];
      end
      n_inv_q <= n_inv;
    end
    d_q <= d_d;
  end

endmodule : mont_mul

// File: tb/tb_mont_mul.sv
// Scoreboarded bench for mont_mul with a bignum reference model.
module tb_mont_mul;

  localparam int W   = 512;
  localparam int L   = 64;
  localparam int NL  = W / L;
  localparam int LAT = NL * (2 * NL + 2) + NL + 1;

  typedef logic [W-1:0] word_t;
  typedef logic [L-1:0] limb_t;

  typedef struct {
    word_t res;
    word_t n;
    int    go_cyc;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  go  = 1'b0;
  word_t a_in = '0;
  word_t b_in = '0;
  word_t n_in = '0;
  limb_t n_inv_in = '0;
  word_t result;
  logic  busy;
  logic  done;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic done_prev = 1'b0;

  mont_mul #(.WIDTH(W), .LIMB(L)) dut (
    .clk    (clk),
    .rst    (rst),
    .go     (go),
    .a      (a_in),
    .b      (b_in),
    .n      (n_in),
    .n_inv  (n_inv_in),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // a*b*2^-W mod n: reduce the full product, then halve modulo n W times.
  function automatic word_t mont_ref(input word_t av, input word_t bv, input word_t nv);
    logic [2*W-1:0] p;
    logic [W:0]     x;
    p = {{W{1'b0}}, av} * {{W{1'b0}}, bv};
    x = (W+1)'(p % {{W{1'b0}}, nv});
    repeat (W) x = x[0] ? ((x + {1'b0, nv}) >> 1) : (x >> 1);
    return x[W-1:0];
  endfunction

  // 2^e mod n by repeated doubling.
  function automatic word_t pow2_mod(input word_t nv, input int e);
    logic [W:0] x;
    x = 1;
    repeat (e) begin
      x = x << 1;
      if (x >= {1'b0, nv}) x = x - {1'b0, nv};
    end
    return x[W-1:0];
  endfunction

  // -n^-1 mod 2^L via Newton iteration.
  function automatic limb_t ninv_ref(input word_t nv);
    limb_t inv, n0;
    n0  = nv[L-1:0];
    inv = 1;
    repeat (7) inv = inv * (limb_t'(2) - n0 * inv);
    return limb_t'(0) - inv;
  endfunction

  function automatic word_t rand_word();
    word_t w;
    for (int k = 0; k < W / 32; k++) w[k*32 +: 32] = $urandom;
    return w;
  endfunction

  // Monitor: pop the oldest expectation on each rising done.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: done rose at cycle %0d with nothing outstanding", cyc);
      end else begin
        e = exp_q.pop_front();
        check("result", result, e.res);
        check("latency", word_t'(cyc - e.go_cyc), word_t'(LAT));
        check("busy_at_done", word_t'(busy), word_t'(0));
        check("result_lt_n", word_t'(result < e.n), word_t'(1));
      end
    end
    done_prev = done;
  end

  task automatic start_op(input word_t av, input word_t bv, input word_t nv, input word_t expv);
    exp_t e;
    @(negedge clk);
    a_in     = av;
    b_in     = bv;
    n_in     = nv;
    n_inv_in = ninv_ref(nv);
    go       = 1'b1;
    e.res    = expv;
    e.n      = nv;
    e.go_cyc = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    go = 1'b0;
    check("busy_after_go", word_t'(busy), word_t'(1));
    check("done_after_go", word_t'(done), word_t'(0));
    a_in     = rand_word();
    b_in     = rand_word();
    n_in     = rand_word();
    n_inv_in = limb_t'(rand_word());
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < LAT + 20) begin
      @(negedge clk);
      k++;
    end
    check("completion", word_t'(exp_q.size()), word_t'(0));
    if (exp_q.size() != 0) exp_q.delete();
  endtask

  initial begin
    word_t n77, rmod, r2, mont5, nv, av, bv;

    repeat (3) @(negedge clk);
    check("reset_done", word_t'(done), word_t'(0));
    check("reset_busy", word_t'(busy), word_t'(0));
    check("reset_result", result, word_t'(0));
    rst = 1'b0;

    n77  = word_t'(77);
    rmod = pow2_mod(n77, W);
    r2   = pow2_mod(n77, 2 * W);

    // R mod n is the Montgomery image of 1, a fixed point of mont(x, x).
    start_op(rmod, rmod, n77, rmod);
    wait_idle();
    repeat (5) @(negedge clk);
    check("hold_done", word_t'(done), word_t'(1));
    check("hold_busy", word_t'(busy), word_t'(0));
    check("hold_result", result, rmod);

    // Into and out of the Montgomery domain.
    mont5 = (word_t'(5) * rmod) % n77;
    start_op(word_t'(5), r2, n77, mont5);
    wait_idle();
    start_op(mont5, word_t'(1), n77, word_t'(5));
    wait_idle();

    start_op(word_t'(76), word_t'(76), n77, mont_ref(word_t'(76), word_t'(76), n77));
    wait_idle();
    start_op(word_t'(0), word_t'(53), n77, word_t'(0));
    wait_idle();

    // A go pulse while busy must not restart the operation.
    start_op(rmod, rmod, n77, rmod);
    repeat (100) @(negedge clk);
    a_in = word_t'(3);
    b_in = word_t'(4);
    go   = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_idle();

    // Abort mid-operation, then run cleanly.
    start_op(word_t'(5), r2, n77, mont5);
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("abort_done", word_t'(done), word_t'(0));
    check("abort_busy", word_t'(busy), word_t'(0));
    check("abort_result", result, word_t'(0));
    start_op(rmod, rmod, n77, rmod);
    wait_idle();

    // Random odd moduli of varied size with operands below n.
    for (int t = 0; t < 200; t++) begin
      nv    = rand_word() >> $urandom_range(0, 400);
      nv[0] = 1'b1;
      if (nv < word_t'(3)) nv = word_t'(3);
      av = rand_word() % nv;
      bv = rand_word() % nv;
      start_op(av, bv, nv, mont_ref(av, bv, nv));
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mont_mul
